// File: rtl/axi_dmem_slave.sv
// AXI4 data-memory responder: 64-bit word SRAM with independent read and write FSMs.
// Single outstanding read and write; INCR and FIXED bursts; out-of-range or illegal beats get SLVERR.
module axi_dmem_slave #(
  parameter int unsigned ID_W      = 4,
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [ID_W-1:0] i_s_awid,
  input  logic [31:0]     i_s_awaddr,
  input  logic [7:0]      i_s_awlen,
  input  logic [1:0]      i_s_awburst,
  input  logic            i_s_awvalid,
  output logic            o_s_awready,
  input  logic [63:0]     i_s_wdata,
  input  logic [7:0]      i_s_wstrb,
  input  logic            i_s_wlast,
  input  logic            i_s_wvalid,
  output logic            o_s_wready,
  output logic [ID_W-1:0] o_s_bid,
  output logic [1:0]      o_s_bresp,
  output logic            o_s_bvalid,
  input  logic            i_s_bready,
  input  logic [ID_W-1:0] i_s_arid,
  input  logic [31:0]     i_s_araddr,
  input  logic [7:0]      i_s_arlen,
  input  logic [1:0]      i_s_arburst,
  input  logic            i_s_arvalid,
  output logic            o_s_arready,
  output logic [ID_W-1:0] o_s_rid,
  output logic [63:0]     o_s_rdata,
  output logic [1:0]      o_s_rresp,
  output logic            o_s_rlast,
  output logic            o_s_rvalid,
  input  logic            i_s_rready
);

  localparam int unsigned AW        = $clog2(DEPTH);
  localparam logic [31:0] MEM_BYTES = 32'(8 * DEPTH);

  typedef enum logic [1:0] {WIdle, WData, WResp} wstate_e;
  typedef enum logic [0:0] {RIdle, RData} rstate_e;

  function automatic logic addr_ok(input logic [31:0] a);
    return (a >= BASE_ADDR) && ((a - BASE_ADDR) < MEM_BYTES);
  endfunction

  function automatic logic [AW-1:0] addr_idx(input logic [31:0] a);
    return AW'((a - BASE_ADDR) >> 3);
  endfunction

  logic [63:0] r_mem [DEPTH];

  // ---------------- write path ----------------
  wstate_e         r_wstate, w_wstate_d;
  logic [ID_W-1:0] r_awid;
  logic [31:0]     r_waddr;
  logic [7:0]      r_awlen, r_wbeat;
  logic [1:0]      r_wburst;
  logic            r_werr;
  logic            w_aw_hs, w_w_hs, w_wlast_beat, w_wburst_ok, w_waddr_ok, w_mem_we, w_wbeat_err;

  always_comb begin
    w_aw_hs      = (r_wstate == WIdle) && i_s_awvalid;
    w_w_hs       = (r_wstate == WData) && i_s_wvalid;
    w_wlast_beat = (r_wbeat == r_awlen);
    w_wburst_ok  = !r_wburst[1];
    w_waddr_ok   = addr_ok(r_waddr);
    w_mem_we     = w_w_hs && w_waddr_ok && w_wburst_ok;
    w_wbeat_err  = !w_waddr_ok || !w_wburst_ok || (i_s_wlast != w_wlast_beat);
    w_wstate_d   = r_wstate;
    unique case (r_wstate)
      WIdle:   if (w_aw_hs) w_wstate_d = WData;
      WData:   if (w_w_hs && (i_s_wlast || w_wlast_beat)) w_wstate_d = WResp;
      WResp:   if (i_s_bready) w_wstate_d = WIdle;
      default: w_wstate_d = WIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_wstate <= WIdle;
    else       r_wstate <= w_wstate_d;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_awid   <= '0;
      r_waddr  <= '0;
      r_awlen  <= '0;
      r_wburst <= '0;
      r_wbeat  <= '0;
      r_werr   <= 1'b0;
    end else if (w_aw_hs) begin
      r_awid   <= i_s_awid;
      r_waddr  <= i_s_awaddr;
      r_awlen  <= i_s_awlen;
      r_wburst <= i_s_awburst;
      r_wbeat  <= '0;
      r_werr   <= 1'b0;
    end else if (w_w_hs) begin
      r_werr  <= r_werr | w_wbeat_err;
      r_wbeat <= r_wbeat + 8'd1;
      if (r_wburst == 2'b01) r_waddr <= r_waddr + 32'd8;
    end
  end

  // Memory has no reset so contents survive a mid-burst reset.
  always_ff @(posedge i_clk) begin
    if (w_mem_we) begin
      for (int b = 0; b < 8; b++) begin
        if (i_s_wstrb[b]) r_mem[addr_idx(r_waddr)][b*8 +: 8] <= i_s_wdata[b*8 +: 8];
      end
    end
  end

  assign o_s_awready = (r_wstate == WIdle);
  assign o_s_wready  = (r_wstate == WData);
  assign o_s_bvalid  = (r_wstate == WResp);
  assign o_s_bresp   = ((r_wstate == WResp) && r_werr) ? 2'b10 : 2'b00;
  assign o_s_bid     = r_awid;

  // ---------------- read path ----------------
  rstate_e         r_rstate, w_rstate_d;
  logic [ID_W-1:0] r_rid;
  logic [31:0]     r_raddr, w_rnext_addr, w_rd_addr;
  logic [7:0]      r_arlen, r_rbeat;
  logic [1:0]      r_rburst;
  logic [63:0]     r_rdata;
  logic [1:0]      r_rresp;
  logic            w_ar_hs, w_r_hs, w_rlast, w_rd_ok, w_rd_load;

  always_comb begin
    w_ar_hs      = (r_rstate == RIdle) && i_s_arvalid;
    w_r_hs       = (r_rstate == RData) && i_s_rready;
    w_rlast      = (r_rstate == RData) && (r_rbeat == r_arlen);
    w_rnext_addr = (r_rburst == 2'b01) ? r_raddr + 32'd8 : r_raddr;
    // The SRAM word for the next beat is fetched on the cycle that frees the R register.
    w_rd_addr    = w_ar_hs ? i_s_araddr : w_rnext_addr;
    w_rd_ok      = addr_ok(w_rd_addr) && !(w_ar_hs ? i_s_arburst[1] : r_rburst[1]);
    w_rd_load    = w_ar_hs || (w_r_hs && !w_rlast);
    w_rstate_d   = r_rstate;
    unique case (r_rstate)
      RIdle:   if (w_ar_hs) w_rstate_d = RData;
      RData:   if (w_r_hs && w_rlast) w_rstate_d = RIdle;
      default: w_rstate_d = RIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_rstate <= RIdle;
    else       r_rstate <= w_rstate_d;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rid    <= '0;
      r_raddr  <= '0;
      r_arlen  <= '0;
      r_rburst <= '0;
      r_rbeat  <= '0;
      r_rdata  <= '0;
      r_rresp  <= '0;
    end else begin
      if (w_ar_hs) begin
        r_rid    <= i_s_arid;
        r_arlen  <= i_s_arlen;
        r_rburst <= i_s_arburst;
        r_rbeat  <= '0;
      end else if (w_r_hs && !w_rlast) begin
        r_rbeat <= r_rbeat + 8'd1;
      end
      if (w_rd_load) begin
        r_raddr <= w_rd_addr;
        r_rdata <= w_rd_ok ? r_mem[addr_idx(w_rd_addr)] : 64'd0;
        r_rresp <= w_rd_ok ? 2'b00 : 2'b10;
      end
    end
  end

  assign o_s_arready = (r_rstate == RIdle);
  assign o_s_rvalid  = (r_rstate == RData);
  assign o_s_rlast   = w_rlast;
  assign o_s_rid     = r_rid;
  assign o_s_rdata   = r_rdata;
  assign o_s_rresp   = r_rresp;

endmodule

// File: tb/tb_axi_dmem_slave.sv
// Directed bench for axi_dmem_slave: single/partial/burst writes, error responses,
// B back-pressure with a concurrent read, early wlast and reset mid-read.
module tb_axi_dmem_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  awid = '0, arid = '0;
  logic [31:0] awaddr = '0, araddr = '0;
  logic [7:0]  awlen = '0, arlen = '0, wstrb = '0;
  logic [1:0]  awburst = '0, arburst = '0;
  logic        awvalid = 0, wlast = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
  logic [63:0] wdata = '0;
  logic        awready, wready, bvalid, arready, rlast, rvalid;
  logic [3:0]  bid, rid;
  logic [1:0]  bresp, rresp;
  logic [63:0] rdata;

  int total = 0;
  int bad   = 0;

  axi_dmem_slave dut (
    .i_clk(clk), .i_rst(rst),
    .i_s_awid(awid), .i_s_awaddr(awaddr), .i_s_awlen(awlen), .i_s_awburst(awburst),
    .i_s_awvalid(awvalid), .o_s_awready(awready),
    .i_s_wdata(wdata), .i_s_wstrb(wstrb), .i_s_wlast(wlast), .i_s_wvalid(wvalid),
    .o_s_wready(wready),
    .o_s_bid(bid), .o_s_bresp(bresp), .o_s_bvalid(bvalid), .i_s_bready(bready),
    .i_s_arid(arid), .i_s_araddr(araddr), .i_s_arlen(arlen), .i_s_arburst(arburst),
    .i_s_arvalid(arvalid), .o_s_arready(arready),
    .o_s_rid(rid), .o_s_rdata(rdata), .o_s_rresp(rresp), .o_s_rlast(rlast),
    .o_s_rvalid(rvalid), .i_s_rready(rready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic timeout(input string what);
    total++;
    bad++;
    $display("FAIL %s timeout: got no handshake, want one within 50 cycles", what);
  endtask

  task automatic aw_send(input logic [31:0] a, input logic [7:0] l, input logic [1:0] b,
                         input logic [3:0] id);
    int n = 0;
    awaddr = a; awlen = l; awburst = b; awid = id; awvalid = 1;
    while (!awready && n < 50) begin tick(); n++; end
    if (n >= 50) timeout("aw");
    tick();
    awvalid = 0;
  endtask

  task automatic w_beat(input logic [63:0] d, input logic [7:0] s, input logic last);
    int n = 0;
    wdata = d; wstrb = s; wlast = last; wvalid = 1;
    while (!wready && n < 50) begin tick(); n++; end
    if (n >= 50) timeout("w");
    tick();
    wvalid = 0; wlast = 0;
  endtask

  task automatic b_recv(output logic [1:0] resp, output logic [3:0] id);
    int n = 0;
    while (!bvalid && n < 50) begin tick(); n++; end
    if (n >= 50) timeout("b");
    resp = bresp; id = bid;
    bready = 1;
    tick();
    bready = 0;
  endtask

  task automatic ar_send(input logic [31:0] a, input logic [7:0] l, input logic [1:0] b,
                         input logic [3:0] id);
    int n = 0;
    araddr = a; arlen = l; arburst = b; arid = id; arvalid = 1;
    while (!arready && n < 50) begin tick(); n++; end
    if (n >= 50) timeout("ar");
    tick();
    arvalid = 0;
  endtask

  task automatic r_beat(output logic [63:0] d, output logic [1:0] resp, output logic last);
    int n = 0;
    rready = 1;
    while (!rvalid && n < 50) begin tick(); n++; end
    if (n >= 50) timeout("r");
    d = rdata; resp = rresp; last = rlast;
    tick();
    rready = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    tick(); tick();
    total++; if (awready !== 1'b1) begin bad++; $display("FAIL rst_awready got=%b want=1", awready); end
    total++; if (arready !== 1'b1) begin bad++; $display("FAIL rst_arready got=%b want=1", arready); end
    total++; if ({wready, bvalid, rvalid, rlast} !== 4'b0) begin
      bad++; $display("FAIL rst_flags got=%b want=0000", {wready, bvalid, rvalid, rlast});
    end
    total++; if ({bid, rid, bresp, rresp} !== 12'h0) begin
      bad++; $display("FAIL rst_ids got=%h want=000", {bid, rid, bresp, rresp});
    end
    total++; if (rdata !== 64'h0) begin bad++; $display("FAIL rst_rdata got=%h want=0", rdata); end
    rst = 0;
    tick();
  endtask

  task automatic test_single();
    logic [1:0] resp; logic [3:0] id;
    aw_send(32'h10, 8'd0, 2'b01, 4'h3);
    w_beat(64'h1122334455667788, 8'hFF, 1'b1);
    b_recv(resp, id);
    total++; if (resp !== 2'b00) begin bad++; $display("FAIL single_bresp got=%b want=00", resp); end
    total++; if (id !== 4'h3) begin bad++; $display("FAIL single_bid got=%h want=3", id); end
    ar_send(32'h10, 8'd0, 2'b01, 4'h5);
    total++; if (rvalid !== 1'b1) begin bad++; $display("FAIL single_rvalid_lat got=%b want=1", rvalid); end
    total++; if (rdata !== 64'h1122334455667788) begin
      bad++; $display("FAIL single_rdata got=%h want=1122334455667788", rdata);
    end
    total++; if ({rlast, rid, rresp} !== {1'b1, 4'h5, 2'b00}) begin
      bad++; $display("FAIL single_rmeta got=%b want=1010100", {rlast, rid, rresp});
    end
    rready = 1; tick(); rready = 0;
    total++; if (rvalid !== 1'b0) begin bad++; $display("FAIL single_rdone got=%b want=0", rvalid); end
  endtask

  task automatic test_partial_strobe();
    logic [1:0] resp; logic [3:0] id; logic [63:0] d; logic last;
    aw_send(32'h20, 8'd0, 2'b01, 4'h1);
    w_beat(64'hAAAAAAAAAAAAAAAA, 8'hFF, 1'b1);
    b_recv(resp, id);
    aw_send(32'h20, 8'd0, 2'b01, 4'h1);
    w_beat(64'h0, 8'h0F, 1'b1);
    b_recv(resp, id);
    ar_send(32'h20, 8'd0, 2'b01, 4'h1);
    r_beat(d, resp, last);
    total++; if (d !== 64'hAAAAAAAA00000000) begin
      bad++; $display("FAIL strobe_rdata got=%h want=aaaaaaaa00000000", d);
    end
  endtask

  task automatic test_incr_burst();
    logic [1:0] resp; logic [3:0] id;
    aw_send(32'h40, 8'd3, 2'b01, 4'h2);
    for (int k = 0; k < 4; k++) w_beat(64'(k + 1), 8'hFF, k == 3);
    b_recv(resp, id);
    total++; if (resp !== 2'b00) begin bad++; $display("FAIL burst_bresp got=%b want=00", resp); end
    ar_send(32'h40, 8'd3, 2'b01, 4'h2);
    for (int k = 0; k < 4; k++) begin
      total++; if (rvalid !== 1'b1 || rdata !== 64'(k + 1) || rlast !== (k == 3)) begin
        bad++; $display("FAIL burst_beat%0d got=%b/%h/%b want=1/%h/%b", k, rvalid, rdata, rlast,
                        64'(k + 1), k == 3);
      end
      tick();
      total++; if (rvalid !== 1'b1 || rdata !== 64'(k + 1) || rlast !== (k == 3)) begin
        bad++; $display("FAIL burst_stall%0d got=%b/%h/%b want=1/%h/%b", k, rvalid, rdata, rlast,
                        64'(k + 1), k == 3);
      end
      rready = 1; tick(); rready = 0;
    end
    total++; if (rvalid !== 1'b0) begin bad++; $display("FAIL burst_end got=%b want=0", rvalid); end
  endtask

  task automatic test_out_of_range();
    logic [1:0] resp; logic [3:0] id; logic [63:0] d; logic last;
    aw_send(32'h0, 8'd0, 2'b01, 4'h0);
    w_beat(64'h0123456789ABCDEF, 8'hFF, 1'b1);
    b_recv(resp, id);
    ar_send(32'h2000, 8'd1, 2'b01, 4'h4);
    for (int k = 0; k < 2; k++) begin
      r_beat(d, resp, last);
      total++; if (d !== 64'h0 || resp !== 2'b10 || last !== (k == 1)) begin
        bad++; $display("FAIL oor_rbeat%0d got=%h/%b/%b want=0/10/%b", k, d, resp, last, k == 1);
      end
    end
    aw_send(32'h2000, 8'd0, 2'b01, 4'h4);
    w_beat(64'hDEADBEEFDEADBEEF, 8'hFF, 1'b1);
    b_recv(resp, id);
    total++; if (resp !== 2'b10) begin bad++; $display("FAIL oor_bresp got=%b want=10", resp); end
    ar_send(32'h0, 8'd0, 2'b01, 4'h0);
    r_beat(d, resp, last);
    total++; if (d !== 64'h0123456789ABCDEF) begin
      bad++; $display("FAIL oor_mem_kept got=%h want=0123456789abcdef", d);
    end
    ar_send(32'h10, 8'd0, 2'b10, 4'h0);
    r_beat(d, resp, last);
    total++; if (d !== 64'h0 || resp !== 2'b10) begin
      bad++; $display("FAIL bad_burst_read got=%h/%b want=0/10", d, resp);
    end
    aw_send(32'h100, 8'd1, 2'b00, 4'h0);
    w_beat(64'h5, 8'hFF, 1'b0);
    w_beat(64'h6, 8'hFF, 1'b1);
    b_recv(resp, id);
    ar_send(32'h100, 8'd0, 2'b01, 4'h0);
    r_beat(d, resp, last);
    total++; if (d !== 64'h6 || resp !== 2'b00) begin
      bad++; $display("FAIL fixed_burst got=%h/%b want=6/00", d, resp);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] resp; logic [3:0] id;
    logic [63:0] rbuf [4];
    int nr = 0;
    aw_send(32'h80, 8'd0, 2'b01, 4'h9);
    w_beat(64'h5555, 8'hFF, 1'b1);
    araddr = 32'h40; arlen = 8'd3; arburst = 2'b01; arid = 4'h6; arvalid = 1; rready = 1;
    awaddr = 32'h88; awlen = 8'd0; awburst = 2'b01; awid = 4'hA; awvalid = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 0) arvalid = 0;
      total++; if ({bvalid, bresp, bid, awready} !== {1'b1, 2'b00, 4'h9, 1'b0}) begin
        bad++; $display("FAIL bstall%0d got=%b want=1000010010", i, {bvalid, bresp, bid, awready});
      end
      if (rvalid && nr < 4) begin rbuf[nr] = rdata; nr++; end
    end
    rready = 0;
    total++; if (nr !== 4) begin bad++; $display("FAIL conc_rbeats got=%0d want=4", nr); end
    for (int k = 0; k < nr; k++) begin
      total++; if (rbuf[k] !== 64'(k + 1)) begin
        bad++; $display("FAIL conc_rdata%0d got=%h want=%h", k, rbuf[k], 64'(k + 1));
      end
    end
    bready = 1; tick(); bready = 0;
    total++; if ({awready, bvalid} !== 2'b10) begin
      bad++; $display("FAIL b_release got=%b want=10", {awready, bvalid});
    end
    tick();
    awvalid = 0;
    total++; if (wready !== 1'b1) begin bad++; $display("FAIL aw_after_b got=%b want=1", wready); end
    w_beat(64'h77, 8'hFF, 1'b1);
    b_recv(resp, id);
    total++; if (resp !== 2'b00 || id !== 4'hA) begin
      bad++; $display("FAIL second_b got=%b/%h want=00/a", resp, id);
    end
  endtask

  task automatic test_early_wlast_and_reset();
    logic [1:0] resp; logic [3:0] id; logic [63:0] d; logic last;
    aw_send(32'hC0, 8'd3, 2'b01, 4'h7);
    w_beat(64'h99, 8'hFF, 1'b1);
    total++; if ({bvalid, bresp, bid, wready} !== {1'b1, 2'b10, 4'h7, 1'b0}) begin
      bad++; $display("FAIL early_wlast got=%b want=1100110", {bvalid, bresp, bid, wready});
    end
    b_recv(resp, id);
    ar_send(32'h40, 8'd3, 2'b01, 4'h1);
    r_beat(d, resp, last);
    total++; if (d !== 64'h1) begin bad++; $display("FAIL pre_rst_beat got=%h want=1", d); end
    rst = 1;
    tick();
    total++; if ({rvalid, arready, rlast} !== 3'b010 || rdata !== 64'h0) begin
      bad++; $display("FAIL mid_rst got=%b/%h want=010/0", {rvalid, arready, rlast}, rdata);
    end
    rst = 0;
    tick();
    ar_send(32'h48, 8'd0, 2'b01, 4'h1);
    r_beat(d, resp, last);
    total++; if (d !== 64'h2 || last !== 1'b1) begin
      bad++; $display("FAIL post_rst_mem got=%h/%b want=2/1", d, last);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_partial_strobe();
    test_incr_burst();
    test_out_of_range();
    test_back_to_back();
    test_early_wlast_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
